// File: rtl/lcd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_arbiter
//  Purpose  : Shares one lcd_controller write channel between two command
//             sources, with the LCD inter-command delay enforced after done.
//             Define LCD_ARB_RR_EN for round-robin, else fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_arbiter #(
    parameter logic [17:0] DELAY = 18'h320C0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       start,
    output logic       RS,
    output logic [7:0] data,
    input  logic       done,
    output logic       busy,
    output logic       owner
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    logic [1:0]  r_state;
    logic [17:0] r_cnt;
    logic        r_rs;
    logic [7:0]  r_data;
    logic        r_owner;
    logic        r_ack0;
    logic        r_ack1;
    logic        w_req_any;
    logic        w_grant1;

    assign w_req_any = req0 | req1;

`ifdef LCD_ARB_RR_EN
    // r_prio names the port that wins the next simultaneous request
    logic r_prio;

    assign w_grant1 = req1 & (~req0 | r_prio);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (r_state == c_IDLE && w_req_any) begin
            r_prio <= ~w_grant1;
        end
    end
`else
    assign w_grant1 = req1 & ~req0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 18'd0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_owner <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_grant1;
                        r_rs    <= w_grant1 ? rs1 : rs0;
                        r_data  <= w_grant1 ? data1 : data0;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (done) begin
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_cnt   <= 18'd0;
                        r_state <= c_GAP;
                    end
                end
                c_GAP: begin
                    // Count runs 0..DELAY, so the gap spans DELAY+1 cycles
                    if (r_cnt == DELAY) begin
                        r_cnt   <= 18'd0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 18'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign start = (r_state == c_START);
    assign busy  = (r_state != c_IDLE);
    assign RS    = r_rs;
    assign data  = r_data;
    assign owner = r_owner;
    assign ack0  = r_ack0;
    assign ack1  = r_ack1;

endmodule
`default_nettype wire

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Two-port arbiter that shares one `lcd_controller` write channel between two independent command sources, for example a power-up init sequencer and a runtime text writer.
- Each requester presents one command: an RS bit and 8-bit data.
- The arbiter grants one requester and latches its command. It then issues a one-cycle `start` to `lcd_controller` and waits for `done`.
- After `done` it acknowledges the granted requester and enforces the LCD inter-command delay before the next grant.
- The block sits between the command sources and `lcd_controller`, and replaces the direct host-side connection.

## Interface
Parameters:
- `DELAY`, default `18'h320C0`: gap after `done`, counted in clock cycles (more than 4.1 ms at 50 MHz). Set to 3 for simulation.

Ports:
- `clk`, in, 1: 50 MHz clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `req0`, in, 1: port 0 command request. The requester holds it high until `ack0`.
- `rs0`, in, 1: port 0 register select (0 = instruction, 1 = data).
- `data0`, in, 8: port 0 command byte.
- `ack0`, out, 1: one-cycle pulse when the port 0 command has completed.
- `req1`, `rs1`, `data1`, `ack1`: same meaning as the port 0 signals, for port 1.
- `start`, out, 1: one-cycle start pulse to `lcd_controller`.
- `RS`, out, 1: latched register select to `lcd_controller`.
- `data`, out, 8: latched command byte to `lcd_controller`.
- `done`, in, 1: completion pulse from `lcd_controller`.
- `busy`, out, 1: high in every state except IDLE.
- `owner`, out, 1: index of the currently or most recently granted port.

## Operation
State machine: IDLE → START → WAIT → GAP → IDLE.
- **IDLE**
  - If `req0` or `req1` is high: select the winner, latch the winner's `rs`/`data` into `RS`/`data`, set `owner`, and go to START.
  - Otherwise stay in IDLE.
- **START**
  - `start` = 1 for exactly this one cycle.
  - Go to WAIT unconditionally.
- **WAIT**
  - Stay until `done` = 1.
  - On `done`: set `ack[owner]` <= 1 for one cycle, clear the counter, go to GAP.
- **GAP**
  - Counter increments from 0. When count == `DELAY`: clear the counter and go to IDLE.
  - GAP therefore lasts `DELAY`+1 cycles.

Behaviour rules:
- `RS`/`data` are registered and held constant from the START cycle until the next grant. Requester inputs may change freely after the grant.
- `done` is ignored in IDLE, START and GAP.
- `req` is sampled only in IDLE.
  - A requester may drop `req` before it is granted; nothing is issued for it.
  - Dropping `req` after the grant does not abort the command; `ack` still pulses.
- To send consecutive commands, the requester keeps `req` high and updates `rs`/`data` in the cycle after `ack`. The next sampling happens in IDLE, after GAP.
- `ack0` and `ack1` are never high in the same cycle.
- Counter width is 18 bits; `DELAY` must fit in 18 bits.

Reset values: state IDLE, `start`=0, `RS`=0, `data`=0x00, `ack0`=0, `ack1`=0, `busy`=0, `owner`=0, counter=0, priority pointer=port 0.

Reset mid-operation:
- The arbiter returns to IDLE immediately and the in-flight command is dropped with no `ack`.
- `lcd_controller` shares the same `reset`.

## Timing
- `req` seen in IDLE at cycle N → `start` high in cycle N+1. `RS`/`data` are valid from cycle N+1.
- `done` sampled high at cycle M → `ack` high in cycle M+1, which is the first GAP cycle.
- With `lcd_controller` (E pulse of 12 clk), `done` arrives 16 cycles after `start`.
- Port-to-port turnaround: the next `start` occurs `DELAY`+3 cycles after `done`.
- `busy` is high from cycle N+1 until the last GAP cycle inclusive.

## Configuration
Macro `LCD_ARB_RR_EN` selects the arbitration policy.
- **Defined: round-robin.**
  - On simultaneous requests, the port opposite the last-served port wins.
  - The pointer updates on each grant.
  - With both requests held continuously, grants alternate 0,1,0,1.
- **Undefined: fixed priority.**
  - Port 0 always wins simultaneous requests.
  - Port 1 is served only when `req0` is low in IDLE.
  - The priority pointer logic is not compiled.

## Test plan
- **Single command:** `DELAY`=3; `req0`=1, `rs0`=0, `data0`=0x01 while idle → `start` 1 cycle later; `RS`=0 and `data`=0x01 held stable; `ack0` pulses exactly once, 1 cycle after `done`; `busy` falls 4 cycles after `ack0`.
- **Input change after grant:** change `data0` to 0x55 the cycle after grant → `data` stays 0x01 until `done`.
- **Simultaneous requests, round-robin (`LCD_ARB_RR_EN` defined):** `req0`=`req1`=1 held for 4 commands → grant order 0,1,0,1; `data` alternates between `data0` and `data1`.
- **Simultaneous requests, fixed priority (`LCD_ARB_RR_EN` undefined):** same stimulus → four grants to port 0 and `ack1` never pulses; drop `req0` → port 1 is granted at the next IDLE.
- **Reset in WAIT:** assert `reset` during WAIT → all outputs return to their reset values immediately; no `ack`; a fresh `req1` afterwards is served normally.
- **Spurious `done`:** force `done`=1 during IDLE and GAP → no state change, no `ack`; GAP still lasts `DELAY`+1 cycles.
